// File: rtl/if_stage_pkg.sv
// Shared CPU definitions used by the fetch stage and the pipeline registers.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    // Fetch stage control state.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register: instr, pc, pc4, valid.
//   flush: drop the held instruction (valid=0, instr=NOP), keep pc fields
//   kill : drop valid only, keep all payload fields
//   load : capture new fields, valid=1
//   none : hold
module ifid_reg
    import if_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic        kill_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    // Register update with priority reset > flush > kill > load > hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (kill_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, next-PC select, RUN/HALTED control,
// fetch counter and the IF/ID register feeding decode.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    input  logic             halt_i,
    output logic [9:0]       im_addr_o,
    input  logic [31:0]      im_dout_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      ifid_instr_o,
    output logic [31:0]      ifid_pc_o,
    output logic [31:0]      ifid_pc4_o,
    output logic             ifid_valid_o,
    output logic             halted_o,
    output logic             addr_err_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             addr_err_q, addr_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pc_plus4;
    logic             ld_ifid, flush_ifid, kill_ifid;

    assign pc_plus4 = pc_q + 32'd4;

    // Next-state decode: halt beats redirect beats stall beats advance.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_err_d = addr_err_q;
        cnt_d      = cnt_q;
        ld_ifid    = 1'b0;
        flush_ifid = 1'b0;
        kill_ifid  = 1'b0;
        if (state_q == ST_RUN) begin
            if (halt_i) begin
                state_d   = ST_HALTED;
                kill_ifid = 1'b1;
            end else if (redirect_i) begin
                pc_d       = {redirect_pc_i[31:2], 2'b00};
                flush_ifid = 1'b1;
                if (redirect_pc_i[1:0] != 2'b00) begin
                    addr_err_d = 1'b1;
                end
            end else if (!stall_i) begin
                pc_d    = pc_plus4;
                ld_ifid = 1'b1;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        end
    end

    // State, PC, sticky error and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            addr_err_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_err_q <= addr_err_d;
            cnt_q      <= cnt_d;
        end
    end

    ifid_reg u_ifid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (ld_ifid),
        .flush_i (flush_ifid),
        .kill_i  (kill_ifid),
        .instr_i (im_dout_i),
        .pc_i    (pc_q),
        .pc4_i   (pc_plus4),
        .instr_o (ifid_instr_o),
        .pc_o    (ifid_pc_o),
        .pc4_o   (ifid_pc4_o),
        .valid_o (ifid_valid_o)
    );

    assign im_addr_o   = pc_q[11:2];
    assign pc_o        = pc_q;
    assign halted_o    = (state_q == ST_HALTED);
    assign addr_err_o  = addr_err_q;
    assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a behavioural model.
module tb_if_stage;

    localparam int CW = 5;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          stall_i = 1'b0;
    logic          redirect_i = 1'b0;
    logic [31:0]   redirect_pc_i = 32'h0;
    logic          halt_i = 1'b0;
    logic [9:0]    im_addr_o;
    logic [31:0]   im_dout_i;
    logic [31:0]   pc_o, ifid_instr_o, ifid_pc_o, ifid_pc4_o;
    logic          ifid_valid_o, halted_o, addr_err_o;
    logic [CW-1:0] fetch_cnt_o;

    logic [31:0] mem [0:1023];

    int n_chk  = 0;
    int n_pass = 0;

    if_stage #(.RESET_PC(32'h0000_3000), .CNT_W(CW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .im_addr_o     (im_addr_o),
        .im_dout_i     (im_dout_i),
        .pc_o          (pc_o),
        .ifid_instr_o  (ifid_instr_o),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_pc4_o    (ifid_pc4_o),
        .ifid_valid_o  (ifid_valid_o),
        .halted_o      (halted_o),
        .addr_err_o    (addr_err_o),
        .fetch_cnt_o   (fetch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Combinational instruction memory.
    assign im_dout_i = mem[im_addr_o];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model of the stage as seen from its outputs.
    logic [31:0]   m_pc, m_instr, m_ipc, m_ipc4;
    logic          m_valid, m_halted, m_err;
    int unsigned   m_cnt;
    bit            m_ok = 0;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_pc = 32'h3000; m_instr = 0; m_ipc = 0; m_ipc4 = 0;
            m_valid = 0; m_halted = 0; m_err = 0; m_cnt = 0; m_ok = 1;
        end else if (m_ok && !m_halted) begin
            if (halt_i) begin
                m_halted = 1;
                m_valid  = 0;
            end else if (redirect_i) begin
                m_pc    = redirect_pc_i & ~32'd3;
                m_valid = 0;
                m_instr = 0;
                if (redirect_pc_i % 4 != 0) m_err = 1;
            end else if (!stall_i) begin
                m_instr = mem[(m_pc / 4) % 1024];
                m_ipc   = m_pc;
                m_ipc4  = m_pc + 4;
                m_valid = 1;
                m_pc    = m_pc + 4;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        if (m_ok) begin
            chk("pc",        pc_o,                m_pc);
            chk("im_addr",   {22'h0, im_addr_o},  (m_pc / 4) % 1024);
            chk("ifid_instr", ifid_instr_o,       m_instr);
            chk("ifid_pc",   ifid_pc_o,           m_ipc);
            chk("ifid_pc4",  ifid_pc4_o,          m_ipc4);
            chk("ifid_valid", {31'h0, ifid_valid_o}, {31'h0, m_valid});
            chk("halted",    {31'h0, halted_o},   {31'h0, m_halted});
            chk("addr_err",  {31'h0, addr_err_o}, {31'h0, m_err});
            chk("fetch_cnt", {{(32-CW){1'b0}}, fetch_cnt_o}, m_cnt);
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = 32'h1000_0000 + k;

        // Reset
        rst_i = 1; cyc(); cyc();
        chk("rst_pc", pc_o, 32'h3000);
        chk("rst_valid", {31'h0, ifid_valid_o}, 32'h0);
        chk("rst_instr", ifid_instr_o, 32'h0);
        chk("rst_cnt", {{(32-CW){1'b0}}, fetch_cnt_o}, 32'h0);
        chk("rst_imaddr", {22'h0, im_addr_o}, 32'h0);
        rst_i = 0;

        // Run four instructions
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("run_ifid_pc", ifid_pc_o, 32'h3000 + 4 * i);
            chk("run_instr", ifid_instr_o, 32'h1000_0000 + i);
            chk("run_valid", {31'h0, ifid_valid_o}, 32'h1);
            chk("run_imaddr", {22'h0, im_addr_o}, i + 1);
        end
        chk("run_cnt", {{(32-CW){1'b0}}, fetch_cnt_o}, 32'd4);
        chk("run_pc", pc_o, 32'h3010);

        // Stall for three cycles
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc", pc_o, 32'h3010);
            chk("stall_ifid_pc", ifid_pc_o, 32'h300C);
            chk("stall_cnt", {{(32-CW){1'b0}}, fetch_cnt_o}, 32'd4);
        end
        stall_i = 0; cyc();
        chk("unstall_ifid_pc", ifid_pc_o, 32'h3010);
        chk("unstall_instr", ifid_instr_o, 32'h1000_0004);

        // Redirect while stalled
        redirect_i = 1; redirect_pc_i = 32'h3100; stall_i = 1; cyc();
        chk("redir_pc", pc_o, 32'h3100);
        chk("redir_valid", {31'h0, ifid_valid_o}, 32'h0);
        chk("redir_imaddr", {22'h0, im_addr_o}, 32'h040);
        redirect_i = 0; stall_i = 0; cyc();
        chk("redir_ifid_pc", ifid_pc_o, 32'h3100);
        chk("redir_ifid_valid", {31'h0, ifid_valid_o}, 32'h1);
        chk("redir_instr", ifid_instr_o, 32'h1000_0040);

        // Misaligned redirect then an aligned one
        redirect_i = 1; redirect_pc_i = 32'h3102; cyc();
        chk("mis_pc", pc_o, 32'h3100);
        chk("mis_err", {31'h0, addr_err_o}, 32'h1);
        redirect_pc_i = 32'h3200; cyc();
        chk("mis_err_sticky", {31'h0, addr_err_o}, 32'h1);
        chk("mis_pc2", pc_o, 32'h3200);

        // Halt and redirect together, then ignored pulses
        halt_i = 1; redirect_pc_i = 32'h3300; cyc();
        chk("halt_halted", {31'h0, halted_o}, 32'h1);
        chk("halt_pc", pc_o, 32'h3200);
        chk("halt_valid", {31'h0, ifid_valid_o}, 32'h0);
        halt_i = 0; redirect_pc_i = 32'h3401; stall_i = 1; cyc();
        redirect_i = 0; stall_i = 0; cyc(); cyc();
        chk("halt_hold_pc", pc_o, 32'h3200);
        chk("halt_hold_err", {31'h0, addr_err_o}, 32'h1);
        chk("halt_cnt", {{(32-CW){1'b0}}, fetch_cnt_o}, 32'd6);
        rst_i = 1; cyc(); rst_i = 0;
        chk("unhalt_pc", pc_o, 32'h3000);
        chk("unhalt_halted", {31'h0, halted_o}, 32'h0);
        chk("unhalt_err", {31'h0, addr_err_o}, 32'h0);

        // PC wrap and counter saturation
        redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFC; cyc();
        redirect_i = 0; cyc();
        chk("wrap_pc", pc_o, 32'h0);
        chk("wrap_ifid_pc", ifid_pc_o, 32'hFFFF_FFFC);
        chk("wrap_pc4", ifid_pc4_o, 32'h0);
        chk("wrap_instr", ifid_instr_o, 32'h1000_03FF);
        for (int i = 0; i < 40; i++) cyc();
        chk("sat_cnt", {{(32-CW){1'b0}}, fetch_cnt_o}, CNT_MAX);

        // Randomized traffic
        for (int k = 0; k < 1024; k++) mem[k] = $urandom;
        for (int i = 0; i < 800; i++) begin
            rst_i         = ($urandom_range(0, 79) == 0);
            halt_i        = ($urandom_range(0, 49) == 0);
            redirect_i    = ($urandom_range(0, 7) == 0);
            stall_i       = ($urandom_range(0, 3) == 0);
            redirect_pc_i = ($urandom_range(0, 3) == 0) ? $urandom
                                                         : ($urandom & 32'h0000_3FFC);
            cyc();
        end
        rst_i = 0; halt_i = 0; redirect_i = 0; stall_i = 0;
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
